// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seg7_pkg;

  // Active-low segment pattern that turns every segment a..g off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low a..g patterns for hex digits 0..F (bit 0 = a, bit 6 = g).
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03,
    7'h27, 7'h21, 7'h06, 7'h0E
  };

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-segment decoder with leading-zero blank and decimal point.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  // Segment bits are active-low, so a lit dp drives bit 7 low.
  always_comb begin
    seg = {~dp, (blank ? SEG_BLANK : SEG_TABLE[hex])};
  end

endmodule

// File: rtl/seg_mux_display.sv
// Multiplexed common-anode hex display driver: slot scan, per-frame input latch,
// leading-zero blanking, blink, PWM brightness and anti-ghosting dead time.
module seg_mux_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIV_COUNT    = 65536,
  parameter int unsigned DEAD_CYCLES  = 16,
  parameter int unsigned BRIGHT_W     = 4,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned SIMULATE     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [7:0]              segments,
  output logic                    tick,
  output logic                    frame_start
);

  localparam int unsigned SLOT_LEN = (SIMULATE != 0) ? (DEAD_CYCLES + 2) : DIV_COUNT;
  localparam int unsigned DIV_W    = clog2_min1(SLOT_LEN);
  localparam int unsigned IDX_W    = clog2_min1(NUM_DIGITS);
  localparam int unsigned FRM_W    = clog2_min1(BLINK_FRAMES);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SLOT_LEN - 1);
  localparam logic [DIV_W-1:0] DEAD_END  = DIV_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // State registers
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FRM_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [BRIGHT_W-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic                    tick_q, tick_d;
  logic                    frame_start_q, frame_start_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    blank_lz_q, blank_lz_d;
  logic [NUM_DIGITS-1:0]   blink_mask_q, blink_mask_d;
  logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
  logic [7:0]              segments_q, segments_d;

  logic slot_end;
  logic frame_end;
  logic pwm_on;

  assign slot_end  = (div_cnt_q == DIV_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);
  assign pwm_on    = (pwm_cnt_q < brightness) || (&brightness);

  // Per-digit view of the latched value and the leading-zero blank mask.
  logic [3:0]            digit [NUM_DIGITS];
  logic [NUM_DIGITS:1]   zero_from;  // zero_from[k]: digits k..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS-1:0] lz_blank;

  assign zero_from[NUM_DIGITS] = 1'b1;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign digit[k] = value_q[4*k +: 4];
    if (k == 0) begin : g_lsd
      assign lz_blank[k] = 1'b0;
    end else begin : g_upper
      assign zero_from[k] = (value_q[4*k +: 4] == 4'h0) && zero_from[k+1];
      assign lz_blank[k]  = blank_lz_q && zero_from[k];
    end
  end

  // Currently scanned digit.
  logic [3:0] cur_hex;
  logic       cur_blank;
  logic       cur_dp;
  logic       cur_blink_off;
  logic [7:0] dec_seg;

  assign cur_hex       = digit[idx_q];
  assign cur_blank     = lz_blank[idx_q];
  assign cur_dp        = dp_q[idx_q];
  assign cur_blink_off = blink_phase_q && blink_mask_q[idx_q];

  seg7_decode u_decode (
    .hex   (cur_hex),
    .blank (cur_blank),
    .dp    (cur_dp),
    .seg   (dec_seg)
  );

  // Slot divider, digit index, frame latch, blink and PWM next state.
  always_comb begin
    div_cnt_d     = div_cnt_q + 1'b1;
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    tick_d        = slot_end;
    frame_start_d = frame_end;
    value_d       = value_q;
    dp_d          = dp_q;
    blank_lz_d    = blank_lz_q;
    blink_mask_d  = blink_mask_q;

    if (slot_end) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (frame_end) begin
      value_d      = value;
      dp_d         = dp;
      blank_lz_d   = blank_lz;
      blink_mask_d = blink_mask;
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Pin drive: anodes stay off through the dead time while segments already switch.
  always_comb begin
    anodes_d   = '1;
    segments_d = 8'hFF;
    if (enable) begin
      if (!cur_blink_off) begin
        segments_d = dec_seg;
      end
      if ((div_cnt_q >= DEAD_END) && pwm_on) begin
        anodes_d[idx_q] = 1'b0;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pwm_cnt_q     <= '0;
      tick_q        <= 1'b0;
      frame_start_q <= 1'b0;
      value_q       <= '0;
      dp_q          <= '0;
      blank_lz_q    <= 1'b0;
      blink_mask_q  <= '0;
      anodes_q      <= '1;
      segments_q    <= 8'hFF;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      tick_q        <= tick_d;
      frame_start_q <= frame_start_d;
      value_q       <= value_d;
      dp_q          <= dp_d;
      blank_lz_q    <= blank_lz_d;
      blink_mask_q  <= blink_mask_d;
      anodes_q      <= anodes_d;
      segments_q    <= segments_d;
    end
  end

  assign anodes      = anodes_q;
  assign segments    = segments_q;
  assign tick        = tick_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_mux_display.sv
// Self-checking bench for seg_mux_display: directed scenarios plus random inputs,
// checked every cycle against a cycle-count based reference model.
module tb_seg_mux_display;

  localparam int N     = 4;
  localparam int DEAD  = 2;
  localparam int SLOT  = DEAD + 2;
  localparam int FRAME = SLOT * N;
  localparam int BF    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [3:0]  brightness;
  logic [3:0]  anodes;
  logic [7:0]  segments;
  logic        tick;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_mux_display #(
    .NUM_DIGITS   (N),
    .DIV_COUNT    (65536),
    .DEAD_CYCLES  (DEAD),
    .BRIGHT_W     (4),
    .BLINK_FRAMES (BF),
    .SIMULATE     (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .value       (value),
    .dp          (dp),
    .blank_lz    (blank_lz),
    .blink_mask  (blink_mask),
    .brightness  (brightness),
    .anodes      (anodes),
    .segments    (segments),
    .tick        (tick),
    .frame_start (frame_start)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: cycles since reset release plus the values latched this frame.
  int          c;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic        m_blz;
  logic [3:0]  m_mask;

  logic [7:0] seg_ref [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E
  };

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  task automatic model_clear();
    c       = 0;
    m_value = '0;
    m_dp    = '0;
    m_blz   = 1'b0;
    m_mask  = '0;
  endtask

  // Predict the outputs after the next rising edge, then advance one cycle and compare.
  task automatic step();
    int         k, pos, f, pwm;
    logic       on, blanked, blink_off;
    logic [3:0] dig;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_tick, e_fs;

    k   = (c / SLOT) % N;
    pos = c % SLOT;
    f   = c / FRAME;
    pwm = c % 16;

    on   = enable && (pos >= DEAD) && ((pwm < int'(brightness)) || (brightness == 4'hF));
    e_an = on ? ~(4'b0001 << k) : 4'hF;

    dig       = 4'((m_value >> (4 * k)) & 16'h000F);
    blanked   = m_blz && (k != 0) && ((m_value >> (4 * k)) == 16'h0000);
    blink_off = (((f / BF) % 2) == 1) && m_mask[k];
    if (!enable || blink_off) e_seg = 8'hFF;
    else e_seg = {~m_dp[k], (blanked ? 7'h7F : seg_ref[dig][6:0])};

    e_tick = (pos == SLOT - 1);
    e_fs   = ((c % FRAME) == FRAME - 1);
    if (e_fs) begin
      m_value = value;
      m_dp    = dp;
      m_blz   = blank_lz;
      m_mask  = blink_mask;
    end
    c++;

    @(negedge clk);
    check("anodes", 16'(anodes), 16'(e_an));
    check("segments", 16'(segments), 16'(e_seg));
    check("tick", 16'(tick), 16'(e_tick));
    check("frame_start", 16'(frame_start), 16'(e_fs));
  endtask

  initial begin
    enable     = 1'b1;
    value      = 16'h12AF;
    dp         = 4'h0;
    blank_lz   = 1'b0;
    blink_mask = 4'h0;
    brightness = 4'hF;
    model_clear();

    repeat (2) @(negedge clk);
    check("rst_anodes", 16'(anodes), 16'h000F);
    check("rst_segments", 16'(segments), 16'h00FF);
    check("rst_tick", 16'(tick), 16'h0000);
    check("rst_frame_start", 16'(frame_start), 16'h0000);
    reset = 1'b0;

    // Basic scan of 12AF at full brightness.
    repeat (3 * FRAME) step();

    // Leading-zero blanking.
    value    = 16'h0030;
    blank_lz = 1'b1;
    repeat (2 * FRAME) step();
    value = 16'h0000;
    repeat (2 * FRAME) step();

    // Mid-frame update only shows from the next frame.
    blank_lz = 1'b0;
    value    = 16'h1111;
    repeat (2 * FRAME) step();
    while ((c % FRAME) != SLOT) step();
    value = 16'h2222;
    repeat (2 * FRAME) step();

    // Brightness.
    brightness = 4'h0;
    repeat (2 * FRAME) step();
    brightness = 4'h4;
    repeat (4 * FRAME) step();
    brightness = 4'hF;

    // Blink on digit 0 with its decimal point lit.
    value      = 16'h1230;
    dp         = 4'b0001;
    blink_mask = 4'b0001;
    repeat (8 * FRAME) step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) value = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 7) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 7) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset asserted mid-slot while a digit is lit.
    enable     = 1'b1;
    brightness = 4'hF;
    blink_mask = 4'h0;
    blank_lz   = 1'b0;
    value      = 16'h8888;
    repeat (2 * FRAME) step();
    while ((c % SLOT) != SLOT - 1) step();
    #2 reset = 1'b1;
    #1;
    check("async_rst_anodes", 16'(anodes), 16'h000F);
    check("async_rst_segments", 16'(segments), 16'h00FF);
    check("async_rst_tick", 16'(tick), 16'h0000);
    check("async_rst_frame_start", 16'(frame_start), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    model_clear();

    // Disabled: pins dark while tick and latching carry on.
    enable = 1'b0;
    repeat (3 * FRAME) step();
    enable = 1'b1;
    repeat (2 * FRAME) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
